// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: accumulates parity over a framed word stream, checks the frame's parity bit and returns one result per frame
module parity_frame_ctrl #(
    parameter int DATA_W    = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 mode,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic                                 in_pbit,
    output logic                                 in_ready,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic                                 res_err,
    output logic                                 res_ovf,
    output logic                                 res_parity,
    output logic [$clog2(MAX_BEATS):0]           res_beats
);
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] BEATS_MAX = CNT_W'(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t           state, state_nxt;
    logic             acc, acc_nxt;
    logic             ovf, ovf_nxt;
    logic             mode_q, mode_nxt;
    logic [CNT_W-1:0] beats, beats_nxt;
    logic             first;
    logic             accept;

    assign in_ready  = state != REPORT;
    assign res_valid = state == REPORT;
    assign accept    = in_valid && in_ready;
    assign first     = state == IDLE;

    // The first beat restarts the frame registers; later beats fold into them and saturate the count.
    always_comb begin
        acc_nxt   = first ? ^in_data : acc ^ (^in_data);
        beats_nxt = first ? CNT_W'(1) : (beats == BEATS_MAX ? beats : beats + 1'b1);
        ovf_nxt   = first ? 1'b0 : (ovf | (beats == BEATS_MAX));
        mode_nxt  = first ? mode : mode_q;
        state_nxt = (state == REPORT) ? (res_ready ? IDLE : REPORT)
                                      : (accept ? (in_last ? REPORT : ACCUM) : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 1'b0;
            ovf        <= 1'b0;
            mode_q     <= 1'b0;
            beats      <= '0;
            res_err    <= 1'b0;
            res_ovf    <= 1'b0;
            res_parity <= 1'b0;
            res_beats  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc    <= acc_nxt;
                ovf    <= ovf_nxt;
                mode_q <= mode_nxt;
                beats  <= beats_nxt;
                if (in_last) begin
                    res_parity <= acc_nxt;
                    res_err    <= (acc_nxt ^ in_pbit ^ mode_nxt) | ovf_nxt;
                    res_ovf    <= ovf_nxt;
                    res_beats  <= beats_nxt;
                end
            end
        end
    end
endmodule
